max_frame_reducer: RTL and testbench
====================================

MAX_FRAME_REDUCER -- requirements
Module: max_frame_reducer

Interface
REQ-001 SHALL have parameter DATA_W, default 5, meaning the width of the max-stage result word consumed per sample.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the per-frame sample counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream max-stage result is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-007 SHALL have port in_data, input, DATA_W bits: unsigned result word from the upstream max stage.
REQ-008 SHALL have port in_last, input, 1 bit: the accepted sample closes the frame.
REQ-009 SHALL have port frame_abort, input, 1 bit: synchronous request to discard the partial frame.
REQ-010 SHALL have port out_valid, output, 1 bit: frame result is available.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the frame result.
REQ-012 SHALL have port out_max, output, DATA_W bits: unsigned maximum over the frame.
REQ-013 SHALL have port out_count, output, CNT_W bits: number of samples in the frame, saturating.
REQ-014 SHALL have port out_sat, output, 1 bit: the frame sample count saturated.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, ACCUM and HOLD.
REQ-016 A sample SHALL be accepted only when in_valid and in_ready are both 1 at a rising clk edge.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD, decoded from state only with no combinational path from in_valid or out_ready.
REQ-018 On acceptance in IDLE: max_reg SHALL load in_data, cnt SHALL load 1, and sat SHALL clear.
REQ-019 After acceptance in IDLE, the FSM SHALL go to HOLD if in_last is 1, otherwise to ACCUM.
REQ-020 On acceptance in ACCUM: max_reg SHALL load the unsigned max of max_reg and in_data; equal values SHALL leave max_reg unchanged.
REQ-021 On acceptance in ACCUM: cnt SHALL increment, saturating at all-ones; when it saturates, sat SHALL set and remain set until the next frame starts.
REQ-022 After acceptance in ACCUM, the FSM SHALL go to HOLD if in_last is 1, otherwise stay in ACCUM.
REQ-023 In HOLD: out_valid SHALL be 1, and out_max, out_count and out_sat SHALL present max_reg, cnt and sat, held stable until out_ready is 1.
REQ-024 In HOLD with out_ready 1, the FSM SHALL go to IDLE next cycle; the frame result SHALL NOT be presented twice.
REQ-025 Latency from the in_last acceptance edge to out_valid high SHALL be exactly 1 cycle; the minimum frame period SHALL be N+1 cycles for N samples.
REQ-026 frame_abort in ACCUM SHALL return the FSM to IDLE, clear max_reg, cnt and sat, and discard any sample accepted in the same cycle (abort wins).
REQ-027 frame_abort SHALL be ignored in IDLE and HOLD; a completed frame SHALL always be delivered.
REQ-028 out_valid SHALL be 0 in IDLE and ACCUM; out_max, out_count and out_sat SHALL be don't-care when out_valid is 0, but driven from registers.

Reset
REQ-029 While rst_n is 0, the FSM SHALL be in IDLE; max_reg, cnt and sat SHALL be 0; out_valid SHALL be 0.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the frame immediately (asynchronously), with no output handshake.
REQ-031 After rst_n deasserts, the first sample SHALL be accepted no earlier than the first rising clk edge at which rst_n is 1.

Structure
REQ-032 A shared package max_stream_pkg SHALL hold the FSM state enum and the default DATA_W and CNT_W constants.
REQ-033 The unsigned compare/select SHALL be a sub-module max_cmp (inputs a and b, output y = max(a,b), purely combinational), reusable by sibling stages.
REQ-034 All outputs SHALL be register- or state-decoded; there SHALL be no input-to-output combinational path.

Verification
REQ-035 Feed frame 3,17,9(last) with out_ready=1 -> out_valid for 1 cycle with out_max=17 and out_count=3; out_sat=0.
REQ-036 Feed a single sample 31 with in_last, and hold out_ready=0 for 5 cycles -> out_max=31 and out_count=1 stable throughout, and in_ready=0 until 1 cycle after out_ready rises.
REQ-037 Feed 300 samples of value 4 then 6(last) with CNT_W=8 -> out_count=255, out_sat=1, out_max=6.
REQ-038 Feed 5,20, then assert frame_abort together with sample 30 -> no output; the next frame 2(last) yields out_max=2 and out_count=1.
REQ-039 Deassert rst_n while in HOLD -> out_valid=0 immediately and in_ready=1 after release; the next frame's result is unaffected.
REQ-040 Run random in_valid/out_ready back-pressure over 1000 frames -> out_max and out_count match the reference model for every frame, with no frame lost or duplicated.

Source files
------------

// File: rtl/max_stream_pkg.sv
// Shared definitions for the max-stream family of stages: default word
// widths and the frame-reducer state encoding.
package max_stream_pkg;

  localparam int DATA_W_DEF = 5;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } frame_state_t;

endpackage

// File: rtl/max_cmp.sv
// Unsigned compare/select: y = max(a, b). Purely combinational so sibling
// stages can drop it into their own datapaths. Ties return a.
module max_cmp #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // pick b only when strictly larger, so equal values keep a
  always_comb begin
    y = a;
    if (b > a) y = b;
  end

endmodule

// File: rtl/max_frame_reducer.sv
// Frame reducer: folds a stream of upstream max-stage words into one result
// per frame (maximum, saturating sample count, saturation flag) and holds it
// until the downstream handshake completes.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no frame open; next accepted sample starts a new frame
//   ACCUM | frame open; samples folded in, frame_abort honoured here only
//   HOLD  | frame closed; result presented until out_ready, input stalled
//
// in_ready and out_valid are kept as flops updated alongside the state, so
// neither depends combinationally on any input.
module max_frame_reducer
  import max_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              frame_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  frame_state_t      state;
  logic [DATA_W-1:0] max_reg;
  logic [DATA_W-1:0] max_next;
  logic [CNT_W-1:0]  cnt;
  logic              sat;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              accept;
  logic              cnt_full;

  assign accept   = in_valid & in_ready_q;
  assign cnt_full = &cnt;

  max_cmp #(.W(DATA_W)) u_max_cmp (
    .a (max_reg),
    .b (in_data),
    .y (max_next)
  );

  // frame FSM with its datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      max_reg     <= '0;
      cnt         <= '0;
      sat         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            max_reg <= in_data;
            cnt     <= CNT_W'(1);
            sat     <= 1'b0;
            if (in_last) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end

        ACCUM: begin
          // abort outranks a sample arriving in the same cycle
          if (frame_abort) begin
            state   <= IDLE;
            max_reg <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
          end else if (accept) begin
            max_reg <= max_next;
            // sat flags that at least one sample went uncounted
            if (cnt_full) sat <= 1'b1;
            else          cnt <= cnt + CNT_W'(1);
            if (in_last) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (out_ready) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = max_reg;
  assign out_count = cnt;
  assign out_sat   = sat;

endmodule

// File: tb/tb_max_frame_reducer.sv
// Directed and randomised-backpressure bench for max_frame_reducer.
module tb_max_frame_reducer;

  localparam int DATA_W = 5;
  localparam int CNT_W  = 8;
  localparam int N_RAND = 1000;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              frame_abort;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_max;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;

  int n_vec;
  int n_miss;

  int exp_max_q[$];
  int exp_cnt_q[$];
  int rx_frames;
  bit tmo;

  max_frame_reducer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .frame_abort (frame_abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_count   (out_count),
    .out_sat     (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one sample presented for exactly one edge; caller ensures in_ready is 1
  task automatic send(input int d, input bit last, input bit abrt);
    in_valid    = 1'b1;
    in_data     = DATA_W'(d);
    in_last     = last;
    frame_abort = abrt;
    tick();
    in_valid    = 1'b0;
    in_last     = 1'b0;
    frame_abort = 1'b0;
  endtask

  task automatic rand_producer();
    for (int f = 0; f < N_RAND && !tmo; f++) begin
      int len;
      int mx;
      len = $urandom_range(1, 8);
      mx  = 0;
      for (int s = 0; s < len && !tmo; s++) begin
        int  d;
        bit  done;
        int  budget;
        d      = $urandom_range(0, 31);
        done   = 1'b0;
        budget = 0;
        if (d > mx) mx = d;
        if (s == len - 1) begin
          exp_max_q.push_back(mx);
          exp_cnt_q.push_back(len);
        end
        while (!done && !tmo) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = DATA_W'(d);
          in_last  = (s == len - 1);
          if (in_valid && in_ready) done = 1'b1;
          tick();
          budget++;
          if (budget > 2000) begin
            chk("rand_in_timeout", 32'd1, 32'd0);
            tmo = 1'b1;
          end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
  endtask

  task automatic rand_consumer();
    int cyc;
    cyc = 0;
    while (rx_frames < N_RAND && !tmo) begin
      out_ready = $urandom_range(0, 1);
      if (out_valid && out_ready) begin
        if (exp_max_q.size() == 0) begin
          chk("rand_dup_frame", 32'd1, 32'd0);
        end else begin
          chk("rand_max", 32'(out_max), 32'(exp_max_q.pop_front()));
          chk("rand_cnt", 32'(out_count), 32'(exp_cnt_q.pop_front()));
        end
        rx_frames++;
      end
      tick();
      cyc++;
      if (cyc > 60000) begin
        chk("rand_out_timeout", 32'd1, 32'd0);
        tmo = 1'b1;
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    rx_frames   = 0;
    tmo         = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    frame_abort = 1'b0;
    out_ready   = 1'b1;

    // reset state
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_max", 32'(out_max), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    rst_n = 1'b1;
    tick();

    // 3,17,9(last) with out_ready high
    send(3, 0, 0);
    chk("f1_no_early_valid", 32'(out_valid), 32'd0);
    send(17, 0, 0);
    send(9, 1, 0);
    chk("f1_valid", 32'(out_valid), 32'd1);
    chk("f1_max", 32'(out_max), 32'd17);
    chk("f1_count", 32'(out_count), 32'd3);
    chk("f1_sat", 32'(out_sat), 32'd0);
    chk("f1_in_ready_hold", 32'(in_ready), 32'd0);
    tick();
    chk("f1_valid_once", 32'(out_valid), 32'd0);
    chk("f1_in_ready_back", 32'(in_ready), 32'd1);

    // single sample 31 with 5 cycles of back-pressure
    out_ready = 1'b0;
    send(31, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("f2_valid", 32'(out_valid), 32'd1);
      chk("f2_max", 32'(out_max), 32'd31);
      chk("f2_count", 32'(out_count), 32'd1);
      chk("f2_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    chk("f2_valid_still", 32'(out_valid), 32'd1);
    tick();
    chk("f2_valid_drop", 32'(out_valid), 32'd0);
    chk("f2_in_ready_back", 32'(in_ready), 32'd1);

    // equal values keep the max, count 2
    send(9, 0, 0);
    send(9, 1, 0);
    chk("eq_max", 32'(out_max), 32'd9);
    chk("eq_count", 32'(out_count), 32'd2);
    tick();

    // 300 x 4 then 6(last): count saturates at 255
    for (int i = 0; i < 300; i++) send(4, 0, 0);
    send(6, 1, 0);
    chk("sat_valid", 32'(out_valid), 32'd1);
    chk("sat_count", 32'(out_count), 32'd255);
    chk("sat_flag", 32'(out_sat), 32'd1);
    chk("sat_max", 32'(out_max), 32'd6);
    tick();

    // next frame clears sat
    send(1, 1, 0);
    chk("sat_clear", 32'(out_sat), 32'd0);
    chk("sat_clear_cnt", 32'(out_count), 32'd1);
    tick();

    // 5,20 then abort together with 30 (last): nothing delivered
    send(5, 0, 0);
    send(20, 0, 0);
    in_valid    = 1'b1;
    in_data     = DATA_W'(30);
    in_last     = 1'b1;
    frame_abort = 1'b1;
    tick();
    in_valid    = 1'b0;
    in_last     = 1'b0;
    frame_abort = 1'b0;
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_cnt_clr", 32'(out_count), 32'd0);
    chk("abort_max_clr", 32'(out_max), 32'd0);
    tick();
    tick();
    chk("abort_still_idle", 32'(out_valid), 32'd0);
    send(2, 1, 0);
    chk("abort_next_valid", 32'(out_valid), 32'd1);
    chk("abort_next_max", 32'(out_max), 32'd2);
    chk("abort_next_cnt", 32'(out_count), 32'd1);
    tick();

    // abort ignored in IDLE (single-sample frame) and in HOLD
    out_ready = 1'b0;
    send(7, 1, 1);
    chk("idle_abort_valid", 32'(out_valid), 32'd1);
    chk("idle_abort_max", 32'(out_max), 32'd7);
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    chk("hold_abort_valid", 32'(out_valid), 32'd1);
    chk("hold_abort_max", 32'(out_max), 32'd7);
    out_ready = 1'b1;
    tick();

    // reset while in HOLD
    out_ready = 1'b0;
    send(12, 1, 0);
    chk("hrst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("hrst_async_valid", 32'(out_valid), 32'd0);
    chk("hrst_async_cnt", 32'(out_count), 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk("hrst_in_ready", 32'(in_ready), 32'd1);
    send(8, 0, 0);
    send(1, 1, 0);
    chk("hrst_next_valid", 32'(out_valid), 32'd1);
    chk("hrst_next_max", 32'(out_max), 32'd8);
    chk("hrst_next_cnt", 32'(out_count), 32'd2);
    tick();

    // random back-pressure against a frame scoreboard
    fork
      rand_producer();
      rand_consumer();
    join
    chk("rand_frames", 32'(rx_frames), 32'(N_RAND));
    chk("rand_leftover", 32'(exp_max_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
